// File: rtl/branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Execute-stage branch resolution unit. Evaluates the six
//               B-type conditions, forms target / fall-through addresses,
//               checks the fetch prediction and registers the result (one
//               cycle latency, single output register, valid/ready on both
//               sides). Also owns a 2-bit saturating BHT that fetch reads
//               combinationally and that is trained on each accepted legal
//               branch.
// Optional    : BRANCH_PERF_EN adds perf_branches / perf_mispredicts
//               counters (handshakes and mispredicted handshakes).
// Ports       : clk, rst (async, active-high)
//               in_valid/in_ready, pc, data1, data2, imm, branch_op,
//               pred_taken, pred_target           : request side
//               out_valid/out_ready, out_taken, out_redirect,
//               out_mispredict, out_illegal       : result side
//               lookup_pc -> lookup_taken         : fetch BHT query
//               perf_branches, perf_mispredicts   : BRANCH_PERF_EN only
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    input  logic [XLEN-1:0]  imm,
    input  logic [2:0]       branch_op,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_redirect,
    output logic             out_mispredict,
    output logic             out_illegal,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken
`ifdef BRANCH_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispredicts
`endif
);

    localparam int c_IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] c_OP_BEQ  = 3'd0;
    localparam logic [2:0] c_OP_BNE  = 3'd1;
    localparam logic [2:0] c_OP_BLT  = 3'd2;
    localparam logic [2:0] c_OP_BGE  = 3'd3;
    localparam logic [2:0] c_OP_BLTU = 3'd4;
    localparam logic [2:0] c_OP_BGEU = 3'd5;

    localparam logic [1:0] c_CNT_RESET = 2'b01;
    localparam logic [1:0] c_CNT_MAX   = 2'b11;
    localparam logic [1:0] c_CNT_MIN   = 2'b00;

    // ------------------------------------------------------------------
    // Condition evaluation and address arithmetic
    // ------------------------------------------------------------------
    logic            w_eq;
    logic            w_lt_s;
    logic            w_lt_u;
    logic            w_taken;
    logic            w_illegal;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_fall;
    logic [XLEN-1:0] w_redirect;
    logic            w_mispredict;
    logic            w_accept;

    assign w_eq   = (data1 == data2);
    assign w_lt_s = ($signed(data1) < $signed(data2));
    assign w_lt_u = (data1 < data2);

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (branch_op)
            c_OP_BEQ:  w_taken = w_eq;
            c_OP_BNE:  w_taken = !w_eq;
            c_OP_BLT:  w_taken = w_lt_s;
            c_OP_BGE:  w_taken = !w_lt_s;
            c_OP_BLTU: w_taken = w_lt_u;
            c_OP_BGEU: w_taken = !w_lt_u;
            default:   w_illegal = 1'b1;
        endcase
    end

    assign w_target     = pc + imm;
    assign w_fall       = pc + XLEN'(4);
    assign w_redirect   = w_taken ? w_target : w_fall;
    // A taken branch with the right direction but wrong target still flushes.
    assign w_mispredict = (w_taken != pred_taken) ||
                          (w_taken && (pred_target != w_target));

    // ------------------------------------------------------------------
    // Handshake: single output register, no skid buffer
    // ------------------------------------------------------------------
    assign in_ready = !out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_taken      <= 1'b0;
            out_redirect   <= '0;
            out_mispredict <= 1'b0;
            out_illegal    <= 1'b0;
        end else if (w_accept) begin
            out_valid      <= 1'b1;
            out_taken      <= w_taken;
            out_redirect   <= w_redirect;
            out_mispredict <= w_mispredict;
            out_illegal    <= w_illegal;
        end else if (out_ready) begin
            // Only the valid flag drops; payload simply goes stale.
            out_valid      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]         r_bht [BHT_ENTRIES];
    logic [c_IDX_W-1:0] w_upd_idx;
    logic [c_IDX_W-1:0] w_lkp_idx;
    logic [1:0]         w_cnt_cur;
    logic [1:0]         w_cnt_next;
    logic               w_unused_lookup;

    assign w_upd_idx = pc[c_IDX_W+1:2];
    assign w_lkp_idx = lookup_pc[c_IDX_W+1:2];
    assign w_cnt_cur = r_bht[w_upd_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (w_taken) begin
            if (w_cnt_cur != c_CNT_MAX) begin
                w_cnt_next = w_cnt_cur + 2'd1;
            end
        end else begin
            if (w_cnt_cur != c_CNT_MIN) begin
                w_cnt_next = w_cnt_cur - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= c_CNT_RESET;
            end
        end else if (w_accept && !w_illegal) begin
            r_bht[w_upd_idx] <= w_cnt_next;
        end
    end

    // Read straight from the array: a same-cycle update is not yet visible,
    // so fetch sees the pre-update counter.
    assign lookup_taken = r_bht[w_lkp_idx][1];

    // Address bits outside the index slice take no part in the lookup.
    assign w_unused_lookup = ^{lookup_pc[XLEN-1:c_IDX_W+2], lookup_pc[1:0]};

`ifdef BRANCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap naturally)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else if (out_valid && out_ready) begin
            perf_branches <= perf_branches + CNT_W'(1);
            if (out_mispredict) begin
                perf_mispredicts <= perf_mispredicts + CNT_W'(1);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/branch_resolve.md
# branch_resolve

Pipelined, parametrised branch resolution unit for the RISC-V execute stage. Evaluates the six B-type conditions on `XLEN`-bit operands, computes the branch target and fall-through address, and compares the outcome against the fetch-stage prediction to produce a redirect/mispredict result one cycle later. It also maintains a 2-bit saturating branch history table (BHT) that fetch reads combinationally and that is trained on every resolved branch. It sits between the register-read/execute boundary and the fetch redirect logic.

## Interface
Parameters:
- `XLEN`, 32: operand, PC and immediate width.
- `BHT_ENTRIES`, 16: BHT depth; power of two, at least 2.
- `CNT_W`, 32: width of the performance counters (used only under `BRANCH_PERF_EN`).

Ports:
- `clk` in 1: clock; the only clock in the block.
- `rst` in 1: reset; asynchronous, active-high.
- `in_valid` in 1: branch request valid.
- `in_ready` out 1: unit can accept a request.
- `pc` in XLEN: PC of the branch.
- `data1` in XLEN: rs1 operand.
- `data2` in XLEN: rs2 operand.
- `imm` in XLEN: sign-extended B-immediate.
- `branch_op` in 3: 0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU; 6 and 7 are illegal.
- `pred_taken` in 1: fetch predicted taken.
- `pred_target` in XLEN: fetch predicted target.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_taken` out 1: resolved direction.
- `out_redirect` out XLEN: correct next PC.
- `out_mispredict` out 1: fetch must be flushed and redirected to `out_redirect`.
- `out_illegal` out 1: `branch_op` was 6 or 7.
- `lookup_pc` in XLEN: fetch BHT query address.
- `lookup_taken` out 1: MSB of the addressed BHT counter (combinational).
- `perf_branches` out CNT_W: resolved branches (under `BRANCH_PERF_EN` only).
- `perf_mispredicts` out CNT_W: resolved mispredictions (under `BRANCH_PERF_EN` only).

## Operation
- Acceptance: a request is accepted when `in_valid && in_ready`.
- Ready: `in_ready = !out_valid || out_ready`. The unit holds a single output register and has no skid buffer.
- Signed compares (BLT, BGE): operands are interpreted as two's complement.
- Unsigned compares (BLTU, BGEU): operands are compared as unsigned.
- Illegal op (6 or 7): result is not taken, `out_illegal=1`, mispredict follows the normal rule below, and the BHT is not updated.
- Address arithmetic:
  - `target = pc + imm`, modulo 2^XLEN.
  - `fall = pc + 4`, modulo 2^XLEN.
  - `out_redirect = taken ? target : fall`.
- Mispredict rule: `out_mispredict = (taken != pred_taken) || (taken && pred_target != target)`.
- BHT indexing: index is `pc[$clog2(BHT_ENTRIES)+1:2]`. The same slice of `lookup_pc` is used for lookups.
- BHT counters: 2-bit saturating.
  - Taken: increment, saturating at 3.
  - Not taken: decrement, saturating at 0.
- BHT training: the counter is updated at the clock edge on which a legal request is accepted.
- Same-index read and write in one cycle: `lookup_taken` returns the pre-update value (read-before-write).
- Output register: loads on acceptance. It holds all `out_*` fields stable while `out_valid && !out_ready`.
- Output drain: `out_valid` clears when the result is taken with no new acceptance in the same cycle.

## Timing
- Latency: 1 cycle. A request accepted at edge N appears on `out_*` after edge N.
- Throughput: one branch per cycle while `out_ready=1`.
- Simultaneous drain and accept: when `out_valid && out_ready && in_valid`, the old result drains and the new one loads on the same edge; `out_valid` stays 1.
- Backpressure: with `out_ready=0` and `out_valid=1`, `in_ready=0` and requests stall. The BHT is not updated for stalled requests.
- Reset values:
  - `out_valid`, `out_taken`, `out_mispredict`, `out_illegal` = 0.
  - `out_redirect` = 0.
  - Every BHT counter = 2'b01 (weakly not taken), so `lookup_taken` = 0.
  - Performance counters = 0.
- Reset mid-operation: any pending result is discarded immediately and `in_ready` becomes 1 after reset deasserts.
- `lookup_taken` is purely combinational from `lookup_pc` and BHT state, and is unaffected by the handshake.

## Configuration
- `BRANCH_PERF_EN` defined:
  - `perf_branches` increments by one on each output handshake (`out_valid && out_ready`).
  - `perf_mispredicts` increments by one on each handshake with `out_mispredict=1`.
  - Both counters wrap modulo 2^CNT_W.
- `BRANCH_PERF_EN` undefined: the `perf_*` ports and their counter logic are absent.

## Test plan
- BLT/BLTU sign distinction: `data1=0xFFFF_FFFF`, `data2=1`, `pc=0x100`, `imm=0x20`.
  - With `branch_op=2` and `pred_taken=1`, `pred_target=0x120`: `out_taken=1`, `out_redirect=0x120`, `out_mispredict=0`.
  - With `branch_op=4`: `out_taken=0`, `out_redirect=0x104`, `out_mispredict=1`.
- Target mismatch: BEQ with `data1=data2=5`, `pc=0x200`, `imm=-8`, `pred_taken=1`, `pred_target=0x1FC` → `out_redirect=0x1F8`, `out_mispredict=1`.
- Backpressure:
  - Three back-to-back requests with `out_ready=0` from cycle 1 → `in_ready=0` after the first acceptance and `out_*` held stable.
  - Raising `out_ready` → the remaining results drain in order, one per cycle.
- BHT training: four taken BNEs at `pc=0x40`.
  - `lookup_pc=0x40` returns `lookup_taken` 0, 1, 1, 1 across the four update edges (counter 1→2→3→3).
  - Two not-taken resolutions → counter 1 and `lookup_taken=0`.
  - `lookup_pc=0x80` (same index for 16 entries) shows aliasing.
- Illegal op and reset: `branch_op=7` → `out_illegal=1`, `out_taken=0`, BHT unchanged. Asserting `rst` while `out_valid=1` → `out_valid=0` immediately and the BHT returns to 01.
- `BRANCH_PERF_EN` build: 10 handshakes including 3 mispredicts → `perf_branches=10`, `perf_mispredicts=3`.
